// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_multiport
//  Purpose  : Parametrised multi-read-port register file with a byte-enabled
//             write port and a built-in clear sequencer. After reset the
//             sequencer zeroes one entry per cycle, so no entry ever reads X.
//             Reads are combinational. While clearing, every read returns 0
//             and writes are discarded (flagged on wr_drop).
//  Ports    : clk      - clock, rising edge
//             reset    - synchronous active-high reset, restarts the clear
//             we       - write enable
//             wa       - write address   [$clog2(DEPTH)]
//             wd       - write data      [WIDTH]
//             wbe      - byte enables    [WIDTH/8], bit i -> wd[8i+7:8i]
//             ra       - packed read addresses, port k = slice k
//             rd       - packed read data,      port k = slice k
//             busy     - high while the clear sequence runs
//             wr_drop  - one-cycle pulse: previous cycle's write was discarded
//  Options  : `define REGFILE_BYPASS_EN for same-cycle write-through on reads
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_multiport #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 32,
   parameter int NREAD   = 2,
   parameter int ZERO_R0 = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             we,
   input  logic [$clog2(DEPTH)-1:0]         wa,
   input  logic [WIDTH-1:0]                 wd,
   input  logic [WIDTH/8-1:0]               wbe,
   input  logic [NREAD*$clog2(DEPTH)-1:0]   ra,
   output logic [NREAD*WIDTH-1:0]           rd,
   output logic                             busy,
   output logic                             wr_drop
);

   localparam int             AW   = $clog2(DEPTH);
   localparam int             NB   = WIDTH / 8;
   localparam logic [AW-1:0]  LAST = AW'(DEPTH - 1);

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t            state, state_nx;
   logic [AW-1:0]     ptr, ptr_nx;
   logic              busy_nx;
   logic              wr_drop_nx;

   logic [WIDTH-1:0]  rf [DEPTH];

   // Writes to entry 0 are architecturally dead when it is hardwired to zero.
   logic              wr_zero_hit;
   assign wr_zero_hit = (ZERO_R0 != 0) && (wa == '0);

   // ------------------------------------------------------------------
   // Control state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= CLEAR;
         ptr     <= '0;
         busy    <= 1'b1;
         wr_drop <= 1'b0;
      end else begin
         state   <= state_nx;
         ptr     <= ptr_nx;
         busy    <= busy_nx;
         wr_drop <= wr_drop_nx;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nx   = state;
      ptr_nx     = ptr;
      busy_nx    = busy;
      wr_drop_nx = 1'b0;
      case (state)
         CLEAR: begin
            ptr_nx     = ptr + AW'(1);
            // Only writes lost to the clear are reported; the zero-entry
            // discard in READY is architectural and stays silent.
            wr_drop_nx = we;
            if (ptr == LAST) begin
               state_nx = READY;
               busy_nx  = 1'b0;
            end
         end
         READY: begin
            busy_nx = 1'b0;
         end
         default: begin
            state_nx = CLEAR;
            ptr_nx   = '0;
            busy_nx  = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Storage array (no reset; the clear sequencer initialises it)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR) begin
            rf[ptr] <= '0;
         end else if (we && !wr_zero_hit) begin
            for (int i = 0; i < NB; i++) begin
               if (wbe[i]) begin
                  rf[wa][8*i +: 8] <= wd[8*i +: 8];
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Combinational read ports
   // ------------------------------------------------------------------
   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;

      assign addr = ra[k*AW +: AW];

      always_comb begin
         data = rf[addr];
`ifdef REGFILE_BYPASS_EN
         // Write-through: merge the enabled bytes of the pending write.
         if (we && (addr == wa)) begin
            for (int i = 0; i < NB; i++) begin
               if (wbe[i]) begin
                  data[8*i +: 8] = wd[8*i +: 8];
               end
            end
         end
`endif
         // Clearing and the hardwired zero entry override everything,
         // including the bypass path.
         if ((state == CLEAR) || ((ZERO_R0 != 0) && (addr == '0))) begin
            data = '0;
         end
      end

      assign rd[k*WIDTH +: WIDTH] = data;
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_multiport
//  Purpose  : Self-checking bench for regfile_multiport. Two instances share
//             all inputs: one with ZERO_R0=1 and one with ZERO_R0=0, both
//             with three read ports, 32 x 32-bit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_multiport;

   localparam int W  = 32;
   localparam int D  = 32;
   localparam int NR = 3;
   localparam int AW = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              we;
   logic [AW-1:0]     wa;
   logic [W-1:0]      wd;
   logic [W/8-1:0]    wbe;
   logic [NR*AW-1:0]  ra;
   logic [NR*W-1:0]   rd;
   logic [NR*W-1:0]   rd0;
   logic              busy, busy0;
   logic              wr_drop, wr_drop0;

   int pass_cnt  = 0;
   int total_cnt = 0;

   string        tag_q[$];
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   regfile_multiport #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .ZERO_R0(1)) dut (
      .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
      .ra(ra), .rd(rd), .busy(busy), .wr_drop(wr_drop)
   );

   regfile_multiport #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .ZERO_R0(0)) dut0 (
      .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
      .ra(ra), .rd(rd0), .busy(busy0), .wr_drop(wr_drop0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string t, input logic [W-1:0] v);
      tag_q.push_back(t);
      exp_q.push_back(v);
   endtask

   task automatic pop_check(input logic [W-1:0] obs);
      string        t;
      logic [W-1:0] e;
      total_cnt = total_cnt + 1;
      if (exp_q.size() == 0) begin
         $error("FAIL scoreboard_empty: observed %h required <none>", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) pass_cnt = pass_cnt + 1;
         else $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
   endtask

   task automatic write(input logic [AW-1:0] a, input logic [W-1:0] d,
                        input logic [W/8-1:0] be);
      we = 1'b1; wa = a; wd = d; wbe = be;
      tick();
      we = 1'b0;
   endtask

   function automatic logic [W-1:0] port(input logic [NR*W-1:0] v, input int k);
      return v[k*W +: W];
   endfunction

   initial begin : main
      int n;
      int bad;
      logic [W-1:0] acc;
      logic [W-1:0] rdw_exp;

      reset = 1'b1; we = 1'b0; wa = '0; wd = '0; wbe = '0; ra = '0;

      // ---------------- reset state ----------------
      tick();
      tick();
      push("reset_busy", 32'd1);
      pop_check({31'd0, busy});
      push("reset_wr_drop", 32'd0);
      pop_check({31'd0, wr_drop});

      // ---------------- clear timing + write during clear ----------------
      reset = 1'b0;
      n   = 0;
      bad = 0;
      for (int i = 1; i <= 40; i++) begin
         we  = (i == 3);
         wa  = 5'd5;
         wd  = 32'hDEADBEEF;
         wbe = 4'hF;
         ra  = 15'($urandom);
         #1;
         for (int k = 0; k < NR; k++) begin
            if (port(rd, k) !== '0 || port(rd0, k) !== '0) bad++;
         end
         tick();
         n++;
         if (i == 3 || i == 4) begin
            push($sformatf("clear_wr_drop_cycle%0d", i), (i == 3) ? 32'd1 : 32'd0);
            pop_check({31'd0, wr_drop});
         end
         if (!busy) break;
      end
      we = 1'b0;
      push("clear_busy_edges", 32'd32);
      pop_check(32'(n));
      push("clear_reads_zero_bad_count", 32'd0);
      pop_check(32'(bad));

      // every entry reads zero afterwards, on both instances
      acc = '0;
      for (int a = 0; a < D; a++) begin
         ra = {NR{5'(a)}};
         #1;
         for (int k = 0; k < NR; k++) acc = acc | port(rd, k) | port(rd0, k);
      end
      push("post_clear_all_entries_or", 32'h0);
      pop_check(acc);
      ra = {NR{5'd5}};
      #1;
      push("dropped_write_entry5", 32'h0);
      pop_check(port(rd0, 0));

      // ---------------- byte enables ----------------
      write(5'd7, 32'h11223344, 4'hF);
      write(5'd7, 32'hAABBCCDD, 4'b0101);
      ra = {NR{5'd7}};
      #1;
      push("byte_enable_merge", 32'h11BB33DD);
      pop_check(port(rd, 1));
      push("byte_enable_wr_drop", 32'd0);
      pop_check({31'd0, wr_drop});

      // ---------------- zero register ----------------
      write(5'd0, 32'hFFFFFFFF, 4'hF);
      ra = {NR{5'd0}};
      #1;
      push("zero_r0_read", 32'h0);
      pop_check(port(rd, 0));
      push("zero_r0_wr_drop", 32'd0);
      pop_check({31'd0, wr_drop});
      push("no_zero_r0_read", 32'hFFFFFFFF);
      pop_check(port(rd0, 2));

      // ---------------- read during write ----------------
      write(5'd9, 32'h1, 4'hF);
      ra = {NR{5'd9}};
      we = 1'b1; wa = 5'd9; wd = 32'h2; wbe = 4'hF;
      #1;
`ifdef REGFILE_BYPASS_EN
      rdw_exp = 32'h2;
`else
      rdw_exp = 32'h1;
`endif
      for (int k = 0; k < NR; k++) begin
         push($sformatf("rdw_before_edge_port%0d", k), rdw_exp);
         pop_check(port(rd, k));
      end
      tick();
      we = 1'b0;
      #1;
      for (int k = 0; k < NR; k++) begin
         push($sformatf("rdw_after_edge_port%0d", k), 32'h2);
         pop_check(port(rd, k));
      end

      // ---------------- reset mid-clear ----------------
      write(5'd3, 32'h5, 4'hF);
      ra = {NR{5'd3}};
      #1;
      push("entry3_before_reset", 32'h5);
      pop_check(port(rd, 0));

      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int j = 0; j < 10; j++) tick();
      push("busy_at_ptr10", 32'd1);
      pop_check({31'd0, busy});
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         n++;
         if (!busy) break;
      end
      push("midclear_busy_edges", 32'd32);
      pop_check(32'(n));
      ra = {NR{5'd3}};
      #1;
      push("midclear_entry3", 32'h0);
      pop_check(port(rd, 2));
      push("midclear_entry3_no_zero_r0", 32'h0);
      pop_check(port(rd0, 1));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
